// File: rtl/irq_ctrl_8_pkg.sv
// Shared constants, FSM state encoding and channel helpers for the irq_ctrl_8 slice.
package irq_ctrl_8_pkg;

  localparam int IRQ_CHANNELS = 8;
  localparam int IRQ_ID_W     = 3;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } irq_state_e;

  // One-hot channel vector for a channel index.
  function automatic logic [IRQ_CHANNELS-1:0] id_to_onehot(input logic [IRQ_ID_W-1:0] id);
    id_to_onehot = 8'd1 << id;
  endfunction

endpackage

// File: rtl/irq_ctrl_8_prio_enc.sv
// Combinational 8:3 encoder; the highest set index wins and a zero input yields index 0.
module prio_enc8_hi (
  input  logic [7:0] din,
  output logic [2:0] idx,
  output logic       nz
);

  // Highest-index priority select.
  always_comb begin
    idx = 3'd0;
    nz  = |din;
    casez (din)
      8'b1???????: idx = 3'd7;
      8'b01??????: idx = 3'd6;
      8'b001?????: idx = 3'd5;
      8'b0001????: idx = 3'd4;
      8'b00001???: idx = 3'd3;
      8'b000001??: idx = 3'd2;
      8'b0000001?: idx = 3'd1;
      8'b00000001: idx = 3'd0;
      default:     idx = 3'd0;
    endcase
  end

endmodule

// File: rtl/irq_ctrl_8.sv
// 8-channel interrupt controller: pending capture, masking, priority select and a
// valid/ready vector offer that clears the pending bit only on a completed handshake.
module irq_ctrl_8
  import irq_ctrl_8_pkg::*;
#(
  parameter logic [7:0] MASK_RST  = 8'hFF,
  parameter bit         EDGE_MODE = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] irq_in,
  input  logic       mask_we,
  input  logic [7:0] mask_wdata,
  output logic       vec_valid,
  output logic [2:0] vec_id,
  input  logic       vec_ready,
  output logic [7:0] pending,
  output logic       irq_any
);

  logic [IRQ_CHANNELS-1:0] irq_q_r;
  logic [IRQ_CHANNELS-1:0] pending_r;
  logic [IRQ_CHANNELS-1:0] mask_r;
  logic [IRQ_CHANNELS-1:0] set_vec_s;
  logic [IRQ_CHANNELS-1:0] clr_vec_s;
  logic [IRQ_CHANNELS-1:0] eligible_s;
  logic [IRQ_ID_W-1:0]     enc_idx_s;
  logic                    enc_nz_s;
  logic                    vec_valid_r;
  logic [IRQ_ID_W-1:0]     vec_id_r;
  irq_state_e              state_r;

  // Request qualification and handshake-driven clear; set wins over clear.
  always_comb begin
    if (EDGE_MODE) begin
      set_vec_s = irq_in & ~irq_q_r;
    end else begin
      set_vec_s = irq_in;
    end
    if (vec_valid_r && vec_ready) begin
      clr_vec_s = id_to_onehot(vec_id_r);
    end else begin
      clr_vec_s = 8'h00;
    end
    eligible_s = pending_r & ~mask_r;
  end

  prio_enc8_hi u_enc (
    .din (eligible_s),
    .idx (enc_idx_s),
    .nz  (enc_nz_s)
  );

  // Input history, pending and mask registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q_r   <= 8'h00;
      pending_r <= 8'h00;
      mask_r    <= MASK_RST;
    end else begin
      irq_q_r   <= irq_in;
      pending_r <= (pending_r & ~clr_vec_s) | set_vec_s;
      if (mask_we) begin
        mask_r <= mask_wdata;
      end else begin
        mask_r <= mask_r;
      end
    end
  end

  // Offer FSM: an offer, once made, is held unchanged until the consumer takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      vec_valid_r <= 1'b0;
      vec_id_r    <= 3'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (enc_nz_s) begin
            vec_id_r    <= enc_idx_s;
            vec_valid_r <= 1'b1;
            state_r     <= ST_OFFER;
          end else begin
            vec_valid_r <= 1'b0;
          end
        end
        ST_OFFER: begin
          if (vec_ready) begin
            vec_valid_r <= 1'b0;
            state_r     <= ST_IDLE;
          end else begin
            vec_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          vec_valid_r <= 1'b0;
          vec_id_r    <= 3'd0;
        end
      endcase
    end
  end

  assign vec_valid = vec_valid_r;
  assign vec_id    = vec_id_r;
  assign pending   = pending_r;
  assign irq_any   = |eligible_s;

endmodule

// File: tb/tb_irq_ctrl_8.sv
// Directed bench for irq_ctrl_8: an edge-mode instance for most steps and a
// level-mode instance for the level-semantics step.
module tb_irq_ctrl_8;

  logic       clk = 1'b0;
  logic       rst, mask_we, rdy;
  logic [7:0] irq, mask_wd;
  logic       v, any;
  logic [2:0] id;
  logic [7:0] pend;

  logic       rst_l, mask_we_l, rdy_l;
  logic [7:0] irq_l, mask_wd_l;
  logic       v_l, any_l;
  logic [2:0] id_l;
  logic [7:0] pend_l;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  irq_ctrl_8 #(.MASK_RST(8'hFF), .EDGE_MODE(1'b1)) dut_e (
    .clk(clk), .rst(rst), .irq_in(irq), .mask_we(mask_we), .mask_wdata(mask_wd),
    .vec_valid(v), .vec_id(id), .vec_ready(rdy), .pending(pend), .irq_any(any)
  );

  irq_ctrl_8 #(.MASK_RST(8'hFF), .EDGE_MODE(1'b0)) dut_l (
    .clk(clk), .rst(rst_l), .irq_in(irq_l), .mask_we(mask_we_l), .mask_wdata(mask_wd_l),
    .vec_valid(v_l), .vec_id(id_l), .vec_ready(rdy_l), .pending(pend_l), .irq_any(any_l)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; mask_we = 1'b0; mask_wd = 8'h00; rdy = 1'b0; irq = 8'h00;
    rst_l = 1'b1; mask_we_l = 1'b0; mask_wd_l = 8'h00; rdy_l = 1'b0; irq_l = 8'h00;
    tick(); tick();
    chk("rst_valid", {31'd0, v}, 32'd0);
    chk("rst_id", {29'd0, id}, 32'd0);
    chk("rst_pend", {24'd0, pend}, 32'd0);
    chk("rst_any", {31'd0, any}, 32'd0);
    chk("rst_l_pend", {24'd0, pend_l}, 32'd0);
    rst = 1'b0; rst_l = 1'b0;

    // 1: single pulse on channel 3
    mask_we = 1'b1; mask_wd = 8'h00; tick(); mask_we = 1'b0;
    irq = 8'h08; tick();
    chk("t1_pend", {24'd0, pend}, 32'h08);
    chk("t1_valid0", {31'd0, v}, 32'd0);
    chk("t1_any", {31'd0, any}, 32'd1);
    irq = 8'h00; rdy = 1'b1; tick();
    chk("t1_valid1", {31'd0, v}, 32'd1);
    chk("t1_id", {29'd0, id}, 32'd3);
    tick();
    chk("t1_pend_clr", {24'd0, pend}, 32'h00);
    chk("t1_valid_clr", {31'd0, v}, 32'd0);
    chk("t1_any_clr", {31'd0, any}, 32'd0);

    // 2: channels 1,5,6 together, ready held high
    irq = 8'h62; tick();
    chk("t2_pend", {24'd0, pend}, 32'h62);
    irq = 8'h00; tick();
    chk("t2_v6", {31'd0, v}, 32'd1);
    chk("t2_id6", {29'd0, id}, 32'd6);
    tick();
    chk("t2_pend_a", {24'd0, pend}, 32'h22);
    chk("t2_gap_a", {31'd0, v}, 32'd0);
    tick();
    chk("t2_id5", {29'd0, id}, 32'd5);
    chk("t2_v5", {31'd0, v}, 32'd1);
    tick();
    chk("t2_pend_b", {24'd0, pend}, 32'h02);
    tick();
    chk("t2_id1", {29'd0, id}, 32'd1);
    chk("t2_v1", {31'd0, v}, 32'd1);
    tick();
    chk("t2_pend_end", {24'd0, pend}, 32'h00);
    chk("t2_v_end", {31'd0, v}, 32'd0);
    rdy = 1'b0;

    // 3: masked ch7, offer of ch2 survives masking it
    mask_we = 1'b1; mask_wd = 8'h80; irq = 8'h84; tick();
    chk("t3_pend", {24'd0, pend}, 32'h84);
    mask_we = 1'b0; irq = 8'h00; tick();
    chk("t3_v", {31'd0, v}, 32'd1);
    chk("t3_id2", {29'd0, id}, 32'd2);
    mask_we = 1'b1; mask_wd = 8'h04; tick(); mask_we = 1'b0;
    chk("t3_v_hold", {31'd0, v}, 32'd1);
    chk("t3_id_hold", {29'd0, id}, 32'd2);
    chk("t3_any", {31'd0, any}, 32'd1);
    tick();
    chk("t3_id_hold2", {29'd0, id}, 32'd2);
    rdy = 1'b1; tick();
    chk("t3_pend_hs", {24'd0, pend}, 32'h80);
    chk("t3_v_hs", {31'd0, v}, 32'd0);
    rdy = 1'b0; tick();
    chk("t3_v7", {31'd0, v}, 32'd1);
    chk("t3_id7", {29'd0, id}, 32'd7);
    rdy = 1'b1; tick();
    chk("t3_pend_end", {24'd0, pend}, 32'h00);
    rdy = 1'b0;

    // 4: new edge on the channel being handshaken; set wins
    irq = 8'h10; tick();
    chk("t4_pend", {24'd0, pend}, 32'h10);
    irq = 8'h00; tick();
    chk("t4_id4", {29'd0, id}, 32'd4);
    rdy = 1'b1; irq = 8'h10; tick();
    chk("t4_pend_keep", {24'd0, pend}, 32'h10);
    chk("t4_v_hs", {31'd0, v}, 32'd0);
    irq = 8'h00; rdy = 1'b0; tick();
    chk("t4_v_again", {31'd0, v}, 32'd1);
    chk("t4_id_again", {29'd0, id}, 32'd4);
    rdy = 1'b1; tick();
    chk("t4_pend_end", {24'd0, pend}, 32'h00);
    rdy = 1'b0;

    // 5: level mode, channel 0 held high
    mask_we_l = 1'b1; mask_wd_l = 8'h00; tick(); mask_we_l = 1'b0;
    irq_l = 8'h01; rdy_l = 1'b1; tick();
    chk("t5_pend", {24'd0, pend_l}, 32'h01);
    tick();
    chk("t5_v_a", {31'd0, v_l}, 32'd1);
    chk("t5_id_a", {29'd0, id_l}, 32'd0);
    tick();
    chk("t5_pend_reset", {24'd0, pend_l}, 32'h01);
    chk("t5_gap", {31'd0, v_l}, 32'd0);
    tick();
    chk("t5_v_b", {31'd0, v_l}, 32'd1);
    irq_l = 8'h00; tick();
    chk("t5_pend_end", {24'd0, pend_l}, 32'h00);
    chk("t5_v_end", {31'd0, v_l}, 32'd0);
    tick(); tick();
    chk("t5_v_idle", {31'd0, v_l}, 32'd0);
    chk("t5_any_idle", {31'd0, any_l}, 32'd0);
    rdy_l = 1'b0;

    // 6: reset while offering ch5
    irq = 8'h20; tick();
    chk("t6_pend", {24'd0, pend}, 32'h20);
    tick();
    chk("t6_v", {31'd0, v}, 32'd1);
    chk("t6_id5", {29'd0, id}, 32'd5);
    rst = 1'b1; tick();
    chk("t6_rst_v", {31'd0, v}, 32'd0);
    chk("t6_rst_id", {29'd0, id}, 32'd0);
    chk("t6_rst_pend", {24'd0, pend}, 32'h00);
    chk("t6_rst_any", {31'd0, any}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_no_offer", {31'd0, v}, 32'd0);
      chk("t6_masked", {31'd0, any}, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
